// File: rtl/delay_arbiter.sv
// delay_arbiter: two-requester arbiter running a shared programmable delay; define DELAY_ARBITER_ROUND_ROBIN_EN for round-robin, else fixed priority to requester 0
module delay_arbiter #(
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] limit0,
   input  logic [WIDTH-1:0] limit1,
   output logic             done0,
   output logic             done1,
   output logic             busy,
   output logic             owner,
   output logic [WIDTH-1:0] count
);
   typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
   state_t state, state_n;
   logic [WIDTH-1:0] limit_q, limit_n, count_n;
   logic owner_n, win, owner_req;
`ifdef DELAY_ARBITER_ROUND_ROBIN_EN
   logic rr, rr_n;
   assign win = req0 ? (req1 & rr) : 1'b1;
`else
   assign win = ~req0;
`endif
   assign owner_req = owner ? req1 : req0;
   assign done0 = (state == DONE) & ~owner;
   assign done1 = (state == DONE) & owner;
   assign busy = state != IDLE;
   // next-state: grant in IDLE, count or abort in COUNT, single pulse in DONE
   always_comb begin
      state_n = state;
      count_n = count;
      limit_n = limit_q;
      owner_n = owner;
`ifdef DELAY_ARBITER_ROUND_ROBIN_EN
      rr_n = rr;
`endif
      case (state)
         IDLE: begin
            count_n = '0;
            if (req0 | req1) begin
               state_n = COUNT;
               owner_n = win;
               limit_n = win ? limit1 : limit0;
            end
         end
         COUNT: begin
            if (!owner_req) begin
               state_n = IDLE;
               count_n = '0;
`ifdef DELAY_ARBITER_ROUND_ROBIN_EN
               rr_n = ~owner;
`endif
            end else if (count == limit_q) state_n = DONE;
            else count_n = count + 1'b1;
         end
         DONE: begin
            state_n = IDLE;
            count_n = '0;
`ifdef DELAY_ARBITER_ROUND_ROBIN_EN
            rr_n = ~owner;
`endif
         end
         default: state_n = IDLE;
      endcase
   end
   // state and datapath registers, reset overriding all inputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
         limit_q <= '0;
         owner <= 1'b0;
`ifdef DELAY_ARBITER_ROUND_ROBIN_EN
         rr <= 1'b0;
`endif
      end else begin
         state <= state_n;
         count <= count_n;
         limit_q <= limit_n;
         owner <= owner_n;
`ifdef DELAY_ARBITER_ROUND_ROBIN_EN
         rr <= rr_n;
`endif
      end
   end
endmodule

// File: tb/tb_delay_arbiter.sv
// tb_delay_arbiter: randomized and directed checks of delay_arbiter against a transaction-level model
module tb_delay_arbiter;
   localparam int W = 6;
   logic clk = 1'b0;
   logic rst, req0, req1;
   logic [W-1:0] limit0, limit1;
   logic done0, done1, busy, owner;
   logic [W-1:0] count;
   int total = 0;
   int bad = 0;
   bit m_act, m_own, m_pref;
   int m_t, m_lim;

   delay_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1),
      .limit0(limit0), .limit1(limit1),
      .done0(done0), .done1(done1), .busy(busy), .owner(owner), .count(count)
   );

   always #5 clk = ~clk;

   function automatic logic [W+3:0] expv();
      logic [W-1:0] c;
      bit dn;
      c = !m_act ? '0 : (m_t <= m_lim + 1 ? W'(m_t - 1) : W'(m_lim));
      dn = m_act && m_t == m_lim + 2;
      return {dn && !m_own, dn && m_own, m_act, m_own, c};
   endfunction

   function automatic logic [W+3:0] obs();
      return {done0, done1, busy, owner, count};
   endfunction

   // advance one clock and update the model from the inputs sampled at that edge
   task automatic tick();
      bit pick;
      @(posedge clk);
      if (rst) begin
         m_act = 0; m_own = 0; m_pref = 0;
      end else if (!m_act) begin
         if (req0 | req1) begin
`ifdef DELAY_ARBITER_ROUND_ROBIN_EN
            pick = m_pref;
`else
            pick = 0;
`endif
            m_own = (req0 && req1) ? pick : req1;
            m_lim = m_own ? int'(limit1) : int'(limit0);
            m_act = 1; m_t = 1;
         end
      end else if (m_t <= m_lim + 1) begin
         if (!(m_own ? req1 : req0)) begin
            m_act = 0; m_pref = !m_own;
         end else m_t++;
      end else begin
         m_act = 0; m_pref = !m_own;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1; req0 = 1; req1 = 1; limit0 = 5; limit1 = 7;
      tick(); tick();
      total++;
      if (obs() !== '0) begin bad++; $display("FAIL reset got=%h exp=0", obs()); end
      total++;
      if (obs() !== expv()) begin bad++; $display("FAIL reset_model got=%h exp=%h", obs(), expv()); end
      req0 = 0; req1 = 0; rst = 0;
      tick();
   endtask

   task automatic test_single();
      req0 = 1; limit0 = 3;
      tick();
      for (int i = 0; i < 6; i++) begin
         total++;
         if (obs() !== expv()) begin bad++; $display("FAIL single_model cyc=%0d got=%h exp=%h", i, obs(), expv()); end
         total++;
         if (done0 !== (i == 4) || done1 !== 1'b0) begin bad++; $display("FAIL single_done cyc=%0d got=%b%b exp=%b0", i, done0, done1, i == 4); end
         if (i < 4) begin
            total++;
            if (count !== W'(i)) begin bad++; $display("FAIL single_count cyc=%0d got=%0d exp=%0d", i, count, i); end
         end
         if (i == 4) req0 = 0;
         tick();
      end
   endtask

   task automatic test_zero_limit();
      req0 = 1; limit0 = 0;
      tick(); tick();
      total++;
      if (done0 !== 1'b1 || obs() !== expv()) begin bad++; $display("FAIL zero_done got=%h exp=%h", obs(), expv()); end
      req0 = 0;
      tick();
      total++;
      if (busy !== 1'b0 || count !== '0) begin bad++; $display("FAIL zero_idle got busy=%b count=%0d exp 0 0", busy, count); end
   endtask

   task automatic test_both();
      int seq[$];
      rst = 1; tick(); rst = 0;
      req0 = 1; req1 = 1; limit0 = 2; limit1 = 4;
      for (int i = 0; i < 40; i++) begin
         tick();
         total++;
         if (obs() !== expv()) begin bad++; $display("FAIL both_model cyc=%0d got=%h exp=%h", i, obs(), expv()); end
         if (done0) seq.push_back(0);
         if (done1) seq.push_back(1);
      end
      total++;
`ifdef DELAY_ARBITER_ROUND_ROBIN_EN
      if (seq.size() < 3 || seq[0] != 0 || seq[1] != 1 || seq[2] != 0) begin bad++; $display("FAIL both_order got n=%0d %p exp 0,1,0", seq.size(), seq); end
`else
      if (seq.size() < 3 || (1 inside {seq})) begin bad++; $display("FAIL both_order got n=%0d %p exp all 0", seq.size(), seq); end
`endif
      req0 = 0; req1 = 0;
      tick(); tick();
   endtask

   task automatic test_abort();
      int n = 0;
      req1 = 1; limit1 = 10;
      tick();
      while (count !== 4 && n < 20) begin tick(); n++; end
      total++;
      if (n >= 20) begin bad++; $display("FAIL abort_wait got count=%0d exp 4", count); end
      req1 = 0;
      tick();
      total++;
      if (busy !== 1'b0 || count !== '0 || done1 !== 1'b0 || obs() !== expv()) begin bad++; $display("FAIL abort got=%h exp=%h", obs(), expv()); end
      for (int i = 0; i < 12; i++) begin
         tick();
         total++;
         if (done1 !== 1'b0) begin bad++; $display("FAIL abort_nodone cyc=%0d got=%b exp=0", i, done1); end
      end
   endtask

   task automatic test_limit_change();
      int n = 1;
      req0 = 1; limit0 = 8;
      tick();
      while (count !== 2 && n < 20) begin tick(); n++; end
      limit0 = 1;
      while (!done0 && n < 30) begin tick(); n++; end
      total++;
      if (n != 10 || obs() !== expv()) begin bad++; $display("FAIL limit_change got cycles=%0d exp 10", n); end
      req0 = 0;
      tick();
   endtask

   task automatic test_reset_mid();
      int n = 0;
      req0 = 1; limit0 = 20;
      tick();
      while (count !== 5 && n < 20) begin tick(); n++; end
      rst = 1;
      tick();
      total++;
      if (obs() !== '0 || obs() !== expv()) begin bad++; $display("FAIL reset_mid got=%h exp=0", obs()); end
      rst = 0; req0 = 0;
      tick();
      total++;
      if (done0 !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_mid_after got done0=%b busy=%b exp 0 0", done0, busy); end
   endtask

   task automatic test_all_ones();
      int n = 1;
      req1 = 1; limit1 = '1;
      tick();
      while (!done1 && n < 80) begin
         total++;
         if (obs() !== expv()) begin bad++; $display("FAIL ones_model cyc=%0d got=%h exp=%h", n, obs(), expv()); end
         tick(); n++;
      end
      total++;
      if (n != (1 << W) + 1) begin bad++; $display("FAIL ones_latency got=%0d exp=%0d", n, (1 << W) + 1); end
      req1 = 0;
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) req0 = ~req0;
         if ($urandom_range(0, 7) == 0) req1 = ~req1;
         if ($urandom_range(0, 3) == 0) limit0 = W'($urandom_range(0, 9));
         if ($urandom_range(0, 3) == 0) limit1 = W'($urandom_range(0, 9));
         rst = $urandom_range(0, 99) == 0;
         tick();
         total++;
         if (obs() !== expv()) begin bad++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs(), expv()); end
         total++;
         if (done0 && done1) begin bad++; $display("FAIL random_excl cyc=%0d got both done exp one", i); end
      end
      rst = 0; req0 = 0; req1 = 0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_zero_limit();
      test_both();
      test_abort();
      test_limit_change();
      test_reset_mid();
      test_all_ones();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/delay_arbiter.md
DELAY_ARBITER -- requirements
Module: delay_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 24: bit width of limits and of the shared delay counter.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req0  input  1  level request from requester 0; held until done0 or abandoned.
REQ-005 SHALL have port req1  input  1  level request from requester 1; same rules as req0.
REQ-006 SHALL have port limit0  input  WIDTH  terminal count for requester 0, sampled at grant.
REQ-007 SHALL have port limit1  input  WIDTH  terminal count for requester 1, sampled at grant.
REQ-008 SHALL have port done0  output  1  one-cycle completion pulse to requester 0.
REQ-009 SHALL have port done1  output  1  one-cycle completion pulse to requester 1.
REQ-010 SHALL have port busy  output  1  high while in COUNT or DONE.
REQ-011 SHALL have port owner  output  1  index of current/last granted requester.
REQ-012 SHALL have port count  output  WIDTH  current shared counter value.

Function
REQ-013 SHALL implement states IDLE, COUNT, DONE, with a registered limit_q, owner and a WIDTH-bit counter.
REQ-014 In IDLE with at least one req high, SHALL grant per arbitration, latch the winner's limit into limit_q, set owner, clear count to 0, and enter COUNT on the next edge.
REQ-015 In IDLE with no req high, SHALL remain in IDLE with count held at 0.
REQ-016 In COUNT, if count == limit_q, SHALL enter DONE; else count SHALL increment by 1.
REQ-017 Count SHALL never wrap; limit_q bounds it, and limit_q = all-ones is legal (2^WIDTH cycles in COUNT).
REQ-018 In DONE, SHALL assert done0 or done1 (selected by owner) for exactly one cycle, then return to IDLE.
REQ-019 Latency from the first edge sampling a granted req in IDLE to the done pulse SHALL be limit_q + 2 cycles; limit 0 yields done on the 2nd cycle.
REQ-020 Changes to limit0/limit1 after grant SHALL NOT affect the running delay.
REQ-021 If the owner's req deasserts while in COUNT, SHALL abort: return to IDLE next edge, clear count, no done pulse.
REQ-022 The non-owner's req SHALL be ignored until IDLE; it is neither lost nor queued beyond its level.
REQ-023 If the owner's req is still high in the IDLE cycle after DONE, it SHALL be treated as a new request.
REQ-024 done0 and done1 SHALL never be high simultaneously, and SHALL be low outside DONE.

Reset
REQ-025 On rst high at a clock edge: state = IDLE; count = 0; limit_q = 0; owner = 0; done0 = done1 = 0; busy = 0; round-robin pointer favours requester 0.
REQ-026 Reset mid-COUNT or in DONE SHALL abort without any done pulse, with rst taking priority over all other inputs.

Configuration
REQ-027 With macro DELAY_ARBITER_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the requester not served last, with the pointer updated on DONE and on abort.
REQ-028 Without DELAY_ARBITER_ROUND_ROBIN_EN, simultaneous requests SHALL always be granted to requester 0 (fixed priority).
REQ-029 A single request SHALL be granted immediately in either configuration.

Verification
REQ-030 req0=1, limit0=3, req1=0 -> count 0,1,2,3 in COUNT; done0 pulse exactly 5 cycles after grant edge; done1 stays 0.
REQ-031 req0=1 with limit0=0 -> done0 on the 2nd cycle after grant, then IDLE.
REQ-032 req0=req1=1 held, limit0=2, limit1=4 -> with macro: done0, then done1, then done0 alternating; without macro: done0 repeatedly and done1 never.
REQ-033 req1 granted with limit1=10, req1 dropped when count=4 -> IDLE next cycle, count=0, no done1.
REQ-034 Grant with limit0=8, limit0 changed to 1 at count=2 -> done0 still after count reaches 8.
REQ-035 rst asserted at count=5 of a limit 20 run -> all outputs at reset values next cycle, no done pulse.
